// File: rtl/mux4_arb_pkg.sv
// Shared types and widths for the 4-way round-robin arbiter and its data mux.
package mux4_arb_pkg;

    localparam int IDX_W = 2;
    localparam int CNT_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

endpackage

// File: rtl/mux4.sv
// Plain 4:1 data multiplexer, one word per requester, selected by index.
module mux4
    import mux4_arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [IDX_W-1:0] sel,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = d0;
        case (sel)
            2'd0: y = d0;
            2'd1: y = d1;
            2'd2: y = d2;
            2'd3: y = d3;
            default: y = d0;
        endcase
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Four-requester round-robin arbiter with bounded burst length and a single
// registered grant; the granted requester's word is steered to out_data.
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic             out_ready,
    output logic [3:0]       grant,
    output logic [1:0]       sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    localparam logic [CNT_W:0] HOLD_LIM = (CNT_W+1)'(MAX_HOLD);

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] ptr_reg, ptr_next;
    logic [IDX_W-1:0] sel_reg, sel_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W:0]   cnt_plus;

    // First set request found scanning upward from the pointer, wrapping at 3.
    function automatic logic [IDX_W-1:0] pick(input logic [3:0] r,
                                              input logic [IDX_W-1:0] p);
        logic [IDX_W-1:0] idx;
        logic             found;
        pick  = p;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = p + IDX_W'(k);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            sel_reg   <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            sel_reg   <= sel_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign cnt_plus = {1'b0, cnt_reg} + (CNT_W+1)'(1);

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        sel_next   = sel_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    sel_next   = pick(req, ptr_reg);
                    state_next = XFER;
                end
            end
            XFER: begin
                // A finished or abandoned grant hands priority to the next index
                // and parks sel at zero so idle outputs match reset.
                if (out_ready && req[sel_reg] && (cnt_plus < HOLD_LIM)) begin
                    cnt_next = cnt_plus[CNT_W-1:0];
                end else if (out_ready || !req[sel_reg]) begin
                    state_next = IDLE;
                    ptr_next   = sel_reg + IDX_W'(1);
                    cnt_next   = '0;
                    sel_next   = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_reg == XFER);
        out_valid = (state_reg == XFER);
        sel       = sel_reg;
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_grant
            assign grant[gi] = (state_reg == XFER) && (sel_reg == IDX_W'(gi));
        end
    endgenerate

    mux4 #(
        .WIDTH (WIDTH)
    ) u_mux (
        .d0  (d0),
        .d1  (d1),
        .d2  (d2),
        .d3  (d3),
        .sel (sel_reg),
        .y   (out_data)
    );

endmodule
